// File: rtl/fp16_dot_sequencer_pkg.sv
// Shared FP16 field layout, sequencer state encoding and helpers.
// Used by fp16_dot_sequencer and its MAC wait timer.
package fp16_dot_sequencer_pkg;

    localparam int unsigned SIGN_BIT = 15;
    localparam int unsigned EXP_MSB  = 14;
    localparam int unsigned EXP_LSB  = 10;
    localparam int unsigned MAN_MSB  = 9;
    localparam int unsigned TMR_W    = 4;

    localparam logic [15:0] FP16_ZERO = 16'h0000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT_MAC,
        S_DONE
    } state_t;

    // +0 or -0: exponent and mantissa all clear, sign ignored
    function automatic logic is_zero(input logic [15:0] v);
        return (v[EXP_MSB:EXP_LSB] == '0) && (v[MAN_MSB:0] == '0);
    endfunction

endpackage

// File: rtl/fp16_dot_sequencer_mac_wait_timer.sv
// Loadable down-counter timing the MAC latency window.
// done is high in the last cycle of the window (count == 1).
module fp16_dot_sequencer_mac_wait_timer #(
    parameter int unsigned TW = 4
) (
    input  logic          CLK,
    input  logic          RESETn,
    input  logic          load,
    input  logic [TW-1:0] load_val,
    input  logic          en,
    output logic          done
);

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    // load wins over decrement; counter parks at zero
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - TW'(1);
        end
    end

    // count register
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == TW'(1));

endmodule

// File: rtl/fp16_dot_sequencer.sv
// FP16 dot-product feeder: streams (a,b) into an external MAC, loops C.
// Optional FP16_ZERO_SKIP_EN: pairs with a zero operand bypass the MAC.
module fp16_dot_sequencer
    import fp16_dot_sequencer_pkg::*;
#(
    parameter int unsigned MAC_LAT = 2,
    parameter int unsigned LEN_W   = 8
) (
    input  logic             CLK,
    input  logic             RESETn,
    input  logic             start,
    input  logic [LEN_W-1:0] vec_len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_a,
    input  logic [15:0]      in_b,
    output logic [15:0]      mac_A,
    output logic [15:0]      mac_B,
    output logic [15:0]      mac_C,
    input  logic [15:0]      mac_out,
    output logic             res_valid,
    output logic [15:0]      res_data,
    output logic             busy
);

    localparam logic [TMR_W-1:0] LAT = TMR_W'(MAC_LAT);

    state_t           state_q, state_d;
    logic [15:0]      acc_q, acc_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [15:0]      mac_a_q, mac_a_d;
    logic [15:0]      mac_b_q, mac_b_d;
    logic [15:0]      mac_c_q, mac_c_d;
    logic [15:0]      res_q, res_d;
    logic             rdy;
    logic             skip;
    logic             tmr_load;
    logic             tmr_en;
    logic             tmr_done;

    fp16_dot_sequencer_mac_wait_timer #(
        .TW(TMR_W)
    ) u_timer (
        .CLK     (CLK),
        .RESETn  (RESETn),
        .load    (tmr_load),
        .load_val(LAT),
        .en      (tmr_en),
        .done    (tmr_done)
    );

`ifdef FP16_ZERO_SKIP_EN
    assign skip = is_zero(in_a) || is_zero(in_b);
`else
    assign skip = 1'b0;
`endif

    // next-state, operand issue and accumulator update
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        mac_a_d  = mac_a_q;
        mac_b_d  = mac_b_q;
        mac_c_d  = mac_c_q;
        res_d    = res_q;
        rdy      = 1'b0;
        tmr_load = 1'b0;
        tmr_en   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    rem_d = vec_len;
                    if (vec_len == '0) begin
                        res_d   = acc_q;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                rdy = 1'b1;
                if (in_valid) begin
                    rem_d = rem_q - LEN_W'(1);
                    if (skip) begin
                        if (rem_q == LEN_W'(1)) begin
                            res_d   = acc_q;
                            state_d = S_DONE;
                        end
                    end else begin
                        mac_a_d  = in_a;
                        mac_b_d  = in_b;
                        mac_c_d  = acc_q;
                        tmr_load = 1'b1;
                        state_d  = S_WAIT_MAC;
                    end
                end
            end
            S_WAIT_MAC: begin
                tmr_en = 1'b1;
                if (tmr_done) begin
                    acc_d = mac_out;
                    if (rem_q == '0) begin
                        res_d   = mac_out;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end
            S_DONE: begin
                acc_d   = FP16_ZERO;
                mac_a_d = FP16_ZERO;
                mac_b_d = FP16_ZERO;
                mac_c_d = FP16_ZERO;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // state, accumulator and MAC operand registers
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q <= S_IDLE;
            acc_q   <= FP16_ZERO;
            rem_q   <= '0;
            mac_a_q <= FP16_ZERO;
            mac_b_q <= FP16_ZERO;
            mac_c_q <= FP16_ZERO;
            res_q   <= FP16_ZERO;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            mac_a_q <= mac_a_d;
            mac_b_q <= mac_b_d;
            mac_c_q <= mac_c_d;
            res_q   <= res_d;
        end
    end

    assign in_ready  = rdy;
    assign mac_A     = mac_a_q;
    assign mac_B     = mac_b_q;
    assign mac_C     = mac_c_q;
    assign res_valid = (state_q == S_DONE);
    assign res_data  = res_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_fp16_dot_sequencer.sv
// Directed bench for fp16_dot_sequencer with a behavioural FP16 MAC
// (latency 2) and a result scoreboard.
module tb_fp16_dot_sequencer;

    logic        CLK = 1'b0;
    logic        RESETn = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  vec_len = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;
    logic [15:0] mac_A, mac_B, mac_C;
    logic [15:0] mac_out;
    logic        res_valid;
    logic [15:0] res_data;
    logic        busy;

    int total = 0;
    int bad = 0;

    logic [15:0] exp_q[$];
    logic [15:0] got_q[$];
    int n_valid = 0;
    int n_rdy = 0;
    int n_issue = 0;
    logic [47:0] prev_bus = '0;
    logic [15:0] mac_pipe = '0;

    fp16_dot_sequencer #(
        .MAC_LAT(2),
        .LEN_W  (8)
    ) dut (
        .CLK      (CLK),
        .RESETn   (RESETn),
        .start    (start),
        .vec_len  (vec_len),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .mac_A    (mac_A),
        .mac_B    (mac_B),
        .mac_C    (mac_C),
        .mac_out  (mac_out),
        .res_valid(res_valid),
        .res_data (res_data),
        .busy     (busy)
    );

    always #5 CLK = ~CLK;

    function automatic real h2r(input logic [15:0] h);
        int e;
        real r;
        e = int'(h[14:10]);
        if (e == 0) return 0.0;
        r = 1.0 + real'(h[9:0]) / 1024.0;
        while (e > 15) begin r = r * 2.0; e--; end
        while (e < 15) begin r = r / 2.0; e++; end
        return h[15] ? -r : r;
    endfunction

    function automatic logic [15:0] r2h(input real x);
        logic s;
        int e;
        int m;
        real r;
        logic [4:0] ef;
        logic [9:0] mf;
        if (x == 0.0) return 16'h0000;
        s = (x < 0.0);
        r = s ? -x : x;
        e = 15;
        while (r >= 2.0) begin r = r / 2.0; e++; end
        while (r < 1.0) begin r = r * 2.0; e--; end
        m = int'((r - 1.0) * 1024.0);
        ef = e[4:0];
        mf = m[9:0];
        return {s, ef, mf};
    endfunction

    // one-stage MAC pipeline: result valid 2 cycles after operands register
    always @(posedge CLK)
        mac_pipe <= r2h(h2r(mac_A) * h2r(mac_B) + h2r(mac_C));
    assign mac_out = mac_pipe;

    // monitor: collect results and activity counters
    always @(negedge CLK) begin
        if (res_valid) begin
            got_q.push_back(res_data);
            n_valid++;
        end
        if (in_ready) n_rdy++;
        if (busy && ({mac_A, mac_B, mac_C} != prev_bus)
            && ({mac_A, mac_B, mac_C} != 48'd0))
            n_issue++;
        prev_bus = {mac_A, mac_B, mac_C};
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_start(input logic [7:0] len, input logic [15:0] expv);
        exp_q.push_back(expv);
        start = 1'b1;
        vec_len = len;
        tick();
        start = 1'b0;
    endtask

    task automatic send_pair(input string tag, input logic [15:0] a,
                             input logic [15:0] b, input int gap);
        bit ok;
        for (int i = 0; i < gap; i++) tick();
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge CLK);
            if (in_ready) ok = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        in_a = $urandom_range(0, 16'hffff);
        in_b = $urandom_range(0, 16'hffff);
        if (!ok) begin
            total++;
            bad++;
            $error("FAIL %s: in_ready timeout got 0 want 1", tag);
        end
    endtask

    task automatic wait_result(input string tag);
        logic [15:0] e;
        logic [15:0] g;
        for (int i = 0; i < 100 && got_q.size() == 0; i++) tick();
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s: scoreboard empty got %0d want 1", tag, 0);
        end else if (got_q.size() == 0) begin
            e = exp_q.pop_front();
            total++;
            bad++;
            $error("FAIL %s: no res_valid got none want %h", tag, e);
        end else begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            check(tag, 32'(g), 32'(e));
        end
    endtask

    initial begin
        int v0;
        int r0;
        int i0;
        int exp_iss;

        #3;
        check("rst_busy", 32'(busy), 0);
        check("rst_ready", 32'(in_ready), 0);
        check("rst_valid", 32'(res_valid), 0);
        check("rst_data", 32'(res_data), 0);
        check("rst_mac", 32'({mac_A, mac_B} | 32'(mac_C)), 0);
        #20;
        RESETn = 1'b1;
        tick();
        tick();

        // T1 / T4: 1*3 + 2*0.5 = 4, extra start pulses ignored
        v0 = n_valid;
        do_start(8'd2, 16'h4400);
        check("t1_busy", 32'(busy), 1);
        send_pair("t1_p0", 16'h3C00, 16'h4200, 0);
        start = 1'b1;
        vec_len = 8'd5;
        tick();
        tick();
        start = 1'b0;
        send_pair("t1_p1", 16'h4000, 16'h3800, 0);
        wait_result("t1_res");
        for (int i = 0; i < 10; i++) tick();
        check("t4_pulses", 32'(n_valid - v0), 1);
        check("t4_idle", 32'(busy), 0);
        check("t1_mac_clr", 32'(mac_A), 0);

        // T2: empty vector
        v0 = n_valid;
        r0 = n_rdy;
        do_start(8'd0, 16'h0000);
        wait_result("t2_res");
        for (int i = 0; i < 4; i++) tick();
        check("t2_noready", 32'(n_rdy - r0), 0);
        check("t2_pulses", 32'(n_valid - v0), 1);

        // T3: three 1*1 pairs with in_valid gaps
        v0 = n_valid;
        do_start(8'd3, 16'h4200);
        send_pair("t3_p0", 16'h3C00, 16'h3C00, 4);
        send_pair("t3_p1", 16'h3C00, 16'h3C00, 4);
        send_pair("t3_p2", 16'h3C00, 16'h3C00, 4);
        wait_result("t3_res");
        for (int i = 0; i < 4; i++) tick();
        check("t3_pulses", 32'(n_valid - v0), 1);

        // T5: reset during second MAC wait
        v0 = n_valid;
        start = 1'b1;
        vec_len = 8'd3;
        tick();
        start = 1'b0;
        send_pair("t5_p0", 16'h4000, 16'h4000, 0);
        send_pair("t5_p1", 16'h4000, 16'h4000, 0);
        #2;
        RESETn = 1'b0;
        #1;
        check("t5_busy", 32'(busy), 0);
        check("t5_ready", 32'(in_ready), 0);
        check("t5_mac", 32'({mac_A, mac_B} | 32'(mac_C)), 0);
        check("t5_data", 32'(res_data), 0);
        tick();
        tick();
        RESETn = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        check("t5_nopulse", 32'(n_valid - v0), 0);
        do_start(8'd2, 16'h4400);
        send_pair("t5_r0", 16'h3C00, 16'h4200, 0);
        send_pair("t5_r1", 16'h4000, 16'h3800, 0);
        wait_result("t5_rerun");

        // T6: zero operand pair then 2*2
`ifdef FP16_ZERO_SKIP_EN
        exp_iss = 1;
`else
        exp_iss = 2;
`endif
        for (int i = 0; i < 3; i++) tick();
        i0 = n_issue;
        do_start(8'd2, 16'h4400);
        send_pair("t6_p0", 16'h0000, 16'h4000, 0);
        send_pair("t6_p1", 16'h4000, 16'h4000, 0);
        wait_result("t6_res");
        check("t6_issues", 32'(n_issue - i0), 32'(exp_iss));

        for (int i = 0; i < 5; i++) tick();
        check("end_sb_empty", 32'(got_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
